// File: rtl/axis_video_rx_checker_pkg.sv
// axis_video_pkg: shared state encoding and error-bit positions for the video receiver
package axis_video_pkg;

    typedef enum logic {WAIT_SOF, IN_FRAME} rx_state_t;

    localparam int ERR_SOF_MISSING = 0;
    localparam int ERR_SOF_EARLY   = 1;
    localparam int ERR_EOL_EARLY   = 2;
    localparam int ERR_EOL_MISSING = 3;

endpackage

// File: rtl/axis_video_rx_checker_xy_counter.sv
// video_xy_counter: pixel x/y tracking with line-end, frame-end and EOL error detection
module video_xy_counter #(
    parameter int DIM_W = 16
) (
    input  logic             i_clk,
    input  logic             i_areset,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic             i_last,
    input  logic [DIM_W-1:0] i_width,
    input  logic [DIM_W-1:0] i_height,
    output logic             o_line_end,
    output logic             o_frame_end,
    output logic             o_eol_early,
    output logic             o_eol_missing
);

    logic [DIM_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0] x_c, y_c, w_c, h_c;
    logic             beat, last_px;

    // A load beat sees position 0,0 and the freshly sampled geometry in the same cycle
    always_comb begin
        beat          = i_load | i_adv;
        x_c           = i_load ? '0 : x_q;
        y_c           = i_load ? '0 : y_q;
        w_c           = i_load ? i_width : w_q;
        h_c           = i_load ? i_height : h_q;
        last_px       = x_c == w_c - DIM_W'(1);
        o_line_end    = beat & (i_last | last_px);
        o_frame_end   = o_line_end & (y_c == h_c - DIM_W'(1));
        o_eol_early   = beat & i_last & ~last_px;
        o_eol_missing = beat & last_px & ~i_last;
        w_d           = w_c;
        h_d           = h_c;
        x_d           = !beat ? x_q : o_line_end ? '0 : x_c + DIM_W'(1);
        y_d           = !beat ? y_q : o_frame_end ? '0 : o_line_end ? y_c + DIM_W'(1) : y_c;
    end

    // Position and latched geometry registers
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            w_q <= w_d;
            h_q <= h_d;
        end
    end

endmodule

// File: rtl/axis_video_rx_checker.sv
// axis_video_rx_checker: AXI4-Stream video sink checking SOF/EOL framing and summing pixels
module axis_video_rx_checker
    import axis_video_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [DIM_W-1:0]      WIDTH,
    input  logic [DIM_W-1:0]      HEIGHT,
    input  logic                  i_stall,
    input  logic                  i_clr_err,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  o_frame_done,
    output logic                  o_frame_ok,
    output logic [CNT_W-1:0]      o_frame_cnt,
    output logic [31:0]           o_checksum,
    output logic [3:0]            o_err,
    output logic                  o_busy
);

    rx_state_t        state_q, state_d;
    logic             tready_q, tready_d;
    logic [31:0]      acc_q, acc_d, sum_q, sum_d;
    logic             ferr_q, ferr_d, ferr_c;
    logic [3:0]       err_q, err_d, ev;
    logic             done_q, done_d, ok_q, ok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat, sof, adv;
    logic             line_end, frame_end, eol_early, eol_missing;

    video_xy_counter #(.DIM_W(DIM_W)) u_xy (
        .i_clk        (i_clk),
        .i_areset     (i_areset),
        .i_load       (sof),
        .i_adv        (adv),
        .i_last       (s_axis_tlast),
        .i_width      (WIDTH),
        .i_height     (HEIGHT),
        .o_line_end   (line_end),
        .o_frame_end  (frame_end),
        .o_eol_early  (eol_early),
        .o_eol_missing(eol_missing)
    );

    // Beat classification, FSM next state, accumulator and error bookkeeping
    always_comb begin
        beat                = s_axis_tvalid & tready_q;
        sof                 = beat & s_axis_tuser;
        adv                 = beat & ~s_axis_tuser & (state_q == IN_FRAME);
        ev                  = '0;
        ev[ERR_SOF_MISSING] = beat & ~s_axis_tuser & (state_q == WAIT_SOF);
        ev[ERR_SOF_EARLY]   = sof & (state_q == IN_FRAME);
        ev[ERR_EOL_EARLY]   = eol_early;
        ev[ERR_EOL_MISSING] = eol_missing;
        ferr_c              = (sof ? 1'b0 : ferr_q) | eol_early | eol_missing;
        tready_d            = ~i_stall;
        acc_d               = sof ? 32'(s_axis_tdata) : adv ? acc_q + 32'(s_axis_tdata) : acc_q;
        ferr_d              = ferr_c;
        err_d               = (i_clr_err ? 4'b0 : err_q) | ev;
        done_d              = frame_end;
        ok_d                = frame_end & ~ferr_c;
        cnt_d               = frame_end ? cnt_q + CNT_W'(1) : cnt_q;
        sum_d               = frame_end ? acc_d : sum_q;
        state_d             = frame_end ? WAIT_SOF : sof ? IN_FRAME : state_q;
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q  <= WAIT_SOF;
            tready_q <= 1'b0;
            acc_q    <= '0;
            sum_q    <= '0;
            ferr_q   <= 1'b0;
            err_q    <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            ferr_q   <= ferr_d;
            err_q    <= err_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign o_frame_done  = done_q;
    assign o_frame_ok    = ok_q;
    assign o_frame_cnt   = cnt_q;
    assign o_checksum    = sum_q;
    assign o_err         = err_q;
    assign o_busy        = state_q == IN_FRAME;

endmodule

// File: tb/tb_axis_video_rx_checker.sv
// tb_axis_video_rx_checker: table, directed and random checks against a frame-level model
module tb_axis_video_rx_checker;

    logic        i_clk = 0, i_areset = 1, i_stall = 0, i_clr_err = 0;
    logic [15:0] WIDTH = 4, HEIGHT = 2;
    logic [7:0]  s_axis_tdata = 0;
    logic        s_axis_tvalid = 0, s_axis_tuser = 0, s_axis_tlast = 0;
    logic        s_axis_tready, o_frame_done, o_frame_ok, o_busy;
    logic [15:0] o_frame_cnt;
    logic [31:0] o_checksum;
    logic [3:0]  o_err;

    int total = 0, bad = 0;

    axis_video_rx_checker dut (
        .i_clk(i_clk), .i_areset(i_areset), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .i_stall(i_stall), .i_clr_err(i_clr_err), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
        .o_frame_cnt(o_frame_cnt), .o_checksum(o_checksum), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model: position within the latched geometry, running sum, flags
    bit          m_in = 0, m_ferr = 0, m_done = 0, m_ok = 0;
    int          m_x = 0, m_y = 0, m_w = 0, m_h = 0;
    logic [31:0] m_sum = 0, m_last = 0;
    logic [3:0]  m_err = 0;
    logic [15:0] m_cnt = 0;

    task automatic model_beat(input int d, input bit u, input bit l);
        if (!u && !m_in) begin
            m_err[0] = 1;
            return;
        end
        if (u) begin
            if (m_in) m_err[1] = 1;
            m_in = 1; m_w = int'(WIDTH); m_h = int'(HEIGHT);
            m_x = 0; m_y = 0; m_sum = 0; m_ferr = 0;
        end
        m_sum = m_sum + 32'(d);
        if (l || m_x == m_w - 1) begin
            if (l && m_x < m_w - 1) begin m_err[2] = 1; m_ferr = 1; end
            if (!l) begin m_err[3] = 1; m_ferr = 1; end
            m_x = 0;
            if (m_y == m_h - 1) begin
                m_in = 0; m_done = 1; m_ok = !m_ferr; m_last = m_sum; m_cnt++;
            end else m_y++;
        end else m_x++;
    endtask

    always @(posedge i_clk) begin
        if (i_areset) begin
            m_in = 0; m_ferr = 0; m_done = 0; m_sum = 0; m_last = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (i_clr_err) m_err = 0;
            if (s_axis_tvalid && s_axis_tready) model_beat(int'(s_axis_tdata), s_axis_tuser, s_axis_tlast);
        end
    end

    bit mon_on = 0;
    int n_done = 0;
    bit last_ok = 0;

    always @(negedge i_clk) begin
        if (mon_on && !i_areset) begin
            chk("err", 32'(o_err), 32'(m_err));
            chk("cnt", 32'(o_frame_cnt), 32'(m_cnt));
            chk("busy", 32'(o_busy), 32'(m_in));
            chk("done", 32'(o_frame_done), 32'(m_done));
            chk("checksum", o_checksum, m_last);
            if (o_frame_done) begin
                n_done++;
                last_ok = o_frame_ok;
                chk("ok", 32'(o_frame_ok), 32'(m_ok));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic send(input logic [7:0] d, input bit u, input bit l);
        int t = 0;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1;
        while (!s_axis_tready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 100) begin
            bad++; total++;
            $display("FAIL tready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(negedge i_clk);
        s_axis_tvalid = 0;
    endtask

    task automatic send_frame(input int w, input int h, input int base);
        for (int i = 0; i < w * h; i++) send(8'(base + i), i == 0, (i % w) == w - 1);
    endtask

    task automatic clr_pulse();
        i_clr_err = 1;
        @(negedge i_clk);
        i_clr_err = 0;
        @(negedge i_clk);
    endtask

    typedef struct {
        logic [15:0] w, h;
        int          n;
        logic [31:0] um, lm;
        logic [7:0]  d0;
        logic        ok;
        logic [3:0]  err;
        logic [31:0] sum;
    } vec_t;

    vec_t tbl[8];
    int   exp_cnt = 0;
    int   d0;
    bit   rnd_on = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'd4, 16'd2, 8, 32'h1, 32'h88, 8'd0,   1'b1, 4'b0000, 32'd28};
        tbl[1] = '{16'd4, 16'd2, 7, 32'h1, 32'h44, 8'd0,   1'b0, 4'b0100, 32'd21};
        tbl[2] = '{16'd4, 16'd2, 8, 32'h1, 32'h00, 8'd0,   1'b0, 4'b1000, 32'd28};
        tbl[3] = '{16'd1, 16'd1, 1, 32'h1, 32'h01, 8'd5,   1'b1, 4'b0000, 32'd5};
        tbl[4] = '{16'd1, 16'd3, 3, 32'h1, 32'h07, 8'd0,   1'b1, 4'b0000, 32'd3};
        tbl[5] = '{16'd3, 16'd1, 3, 32'h1, 32'h04, 8'd0,   1'b1, 4'b0000, 32'd3};
        tbl[6] = '{16'd2, 16'd2, 4, 32'h1, 32'h0A, 8'd200, 1'b1, 4'b0000, 32'd806};
        tbl[7] = '{16'd4, 16'd1, 1, 32'h1, 32'h01, 8'd9,   1'b0, 4'b0100, 32'd9};

        repeat (3) @(negedge i_clk);
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_done", 32'(o_frame_done), 0);
        chk("rst_ok", 32'(o_frame_ok), 0);
        chk("rst_cnt", 32'(o_frame_cnt), 0);
        chk("rst_sum", o_checksum, 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_busy", 32'(o_busy), 0);
        i_areset = 0;
        @(negedge i_clk);
        chk("tready_after_rst", 32'(s_axis_tready), 1);
        mon_on = 1;

        for (int k = 0; k < 8; k++) begin
            WIDTH = tbl[k].w; HEIGHT = tbl[k].h;
            clr_pulse();
            chk("clr_err", 32'(o_err), 0);
            d0 = n_done;
            for (int i = 0; i < tbl[k].n; i++) send(tbl[k].d0 + 8'(i), tbl[k].um[i], tbl[k].lm[i]);
            repeat (2) @(negedge i_clk);
            exp_cnt++;
            chk("tbl_done", 32'(n_done - d0), 1);
            chk("tbl_ok", 32'(last_ok), 32'(tbl[k].ok));
            chk("tbl_err", 32'(o_err), 32'(tbl[k].err));
            chk("tbl_sum", o_checksum, tbl[k].sum);
            chk("tbl_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        end

        WIDTH = 4; HEIGHT = 2;
        clr_pulse();
        for (int f = 0; f < 3; f++) send_frame(4, 2, 0);
        @(negedge i_clk);
        exp_cnt += 3;
        chk("b2b_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        chk("b2b_sum", o_checksum, 28);
        send(8'd50, 0, 0);
        send(8'd51, 0, 1);
        send_frame(4, 2, 0);
        repeat (2) @(negedge i_clk);
        exp_cnt++;
        chk("nosof_err", 32'(o_err), 32'b0001);
        chk("nosof_ok", 32'(last_ok), 1);
        chk("nosof_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

        clr_pulse();
        d0 = n_done;
        for (int i = 0; i < 5; i++) send(8'(100 + i), i == 0, i == 3);
        send_frame(4, 2, 0);
        repeat (2) @(negedge i_clk);
        exp_cnt++;
        chk("restart_err", 32'(o_err), 32'b0010);
        chk("restart_done", 32'(n_done - d0), 1);
        chk("restart_sum", o_checksum, 28);
        chk("restart_ok", 32'(last_ok), 1);
        chk("restart_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

        clr_pulse();
        d0 = n_done;
        fork
            send_frame(4, 2, 0);
            begin
                repeat (3) @(negedge i_clk);
                i_stall = 1;
                @(negedge i_clk);
                chk("stall_tready", 32'(s_axis_tready), 0);
                repeat (9) @(negedge i_clk);
                i_stall = 0;
            end
        join
        repeat (2) @(negedge i_clk);
        exp_cnt++;
        chk("stall_done", 32'(n_done - d0), 1);
        chk("stall_sum", o_checksum, 28);
        chk("stall_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

        for (int i = 0; i < 3; i++) send(8'(i), i == 0, 0);
        i_areset = 1;
        #1;
        chk("arst_tready", 32'(s_axis_tready), 0);
        chk("arst_cnt", 32'(o_frame_cnt), 0);
        chk("arst_sum", o_checksum, 0);
        chk("arst_err", 32'(o_err), 0);
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_done", 32'(o_frame_done), 0);
        repeat (2) @(negedge i_clk);
        i_areset = 0;
        @(negedge i_clk);

        rnd_on = 1;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int w, h;
                    w = $urandom_range(1, 5);
                    h = $urandom_range(1, 3);
                    WIDTH = 16'(w); HEIGHT = 16'(h);
                    for (int i = 0; i < w * h; i++)
                        send(8'($urandom), i == 0 ? ($urandom % 8 != 0) : ($urandom % 40 == 0),
                             ((i % w) == w - 1) ^ ($urandom % 15 == 0));
                end
                rnd_on = 0;
            end
            while (rnd_on) begin
                @(negedge i_clk);
                i_stall = rnd_on && ($urandom % 5 == 0);
                i_clr_err = rnd_on && ($urandom % 25 == 0);
            end
        join
        i_stall = 0; i_clr_err = 0;
        WIDTH = 4; HEIGHT = 2;
        @(negedge i_clk);
        send_frame(4, 2, 0);
        repeat (3) @(negedge i_clk);
        chk("final_sum", o_checksum, 28);
        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_video_rx_checker.md
Name: axis_video_rx_checker

Overview:
- Synthesizable AXI4-Stream video sink; the receiving end of the video stream the remapper emits.
- Accepts pixels and tracks the x/y position of each.
- Checks framing: tuser = start of frame (SOF), tlast = end of line (EOL), against runtime WIDTH/HEIGHT.
- Reports per-frame completion, frame count, a 32-bit pixel checksum and sticky error flags; used on hardware and in benches as a self-checking receiver.

Parameters:
- DATA_WIDTH, 8, pixel width in bits (tdata width).
- DIM_W, 16, width of the WIDTH/HEIGHT ports and the internal x/y counters.
- CNT_W, 16, width of the frame counter.

Ports:
- i_clk  in  1  system clock.
- i_areset  in  1  asynchronous active-high reset.
- WIDTH  in  DIM_W  pixels per line; sampled on SOF acceptance; legal range 1..2^DIM_W-1.
- HEIGHT  in  DIM_W  lines per frame; sampled on SOF acceptance; legal range 1..2^DIM_W-1.
- i_stall  in  1  backpressure request; forces tready low.
- i_clr_err  in  1  single-cycle pulse; clears the sticky error flags.
- s_axis_tdata  in  DATA_WIDTH  pixel.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tuser  in  1  SOF marker.
- s_axis_tlast  in  1  EOL marker.
- s_axis_tready  out  1  registered ready.
- o_frame_done  out  1  one-cycle pulse at the end of each completed frame.
- o_frame_ok  out  1  valid with o_frame_done; 1 = the completed frame had no framing errors.
- o_frame_cnt  out  CNT_W  number of completed frames; wraps modulo 2^CNT_W.
- o_checksum  out  32  sum of the pixels of the last completed frame.
- o_err  out  4  sticky flags: bit0 sof_missing, bit1 sof_early, bit2 eol_early, bit3 eol_missing.
- o_busy  out  1  1 while in IN_FRAME.

Behaviour:
- Reset values: all outputs 0; state WAIT_SOF; x = 0, y = 0; accumulator 0.
- A beat is accepted when tvalid && tready.
- tready register: loads ~i_stall every cycle. Stall takes effect one cycle after i_stall changes. tready is first high one cycle after reset release, provided i_stall is 0.
- Accumulator: 32-bit, adds zero-extended tdata on each in-frame accepted beat, wraps modulo 2^32.
- WAIT_SOF, beat without tuser: beat is dropped; set err[0].
- WAIT_SOF, beat with tuser:
  - latch WIDTH and HEIGHT into internal W and H;
  - accumulator loads tdata;
  - frame error flag clears;
  - x = 1, y = 0, unless the beat also ends the line (see line end);
  - go to IN_FRAME.
- IN_FRAME, beat with tuser: set err[1]. The current frame is aborted: no o_frame_done, no count increment. The beat restarts the frame exactly as a WAIT_SOF tuser beat.
- Line end occurs on an accepted beat in either of two cases:
  - tlast = 1 with x < W-1: set err[2] (eol_early); the line is short.
  - x == W-1: if tlast = 0, set err[3] (eol_missing). The line is still ended, so the count resyncs to WIDTH.
- Line end with y < H-1: x = 0, y increments.
- Line end with y == H-1 (frame end):
  - next cycle: o_frame_done = 1;
  - o_checksum = accumulator including the last pixel;
  - o_frame_cnt increments;
  - o_frame_ok = no error occurred since this frame's SOF;
  - go to WAIT_SOF.
- WIDTH = 1: every beat must carry tlast. HEIGHT = 1: the first line end completes the frame.
- SOF beat that is also a frame end (WIDTH = 1 and HEIGHT = 1): completes the frame immediately with o_frame_done.
- Error flags:
  - any error also marks the current frame not ok;
  - i_clr_err clears o_err next cycle;
  - an error event in the same cycle as i_clr_err wins, so that flag stays 1.
- i_areset asserted mid-frame: immediate return to the reset state. The partial frame is lost and o_frame_cnt returns to 0.
- Latency: o_frame_done is 1 cycle after acceptance of the final beat. The error flags update 1 cycle after the offending beat.

Decomposition:
- Package axis_video_pkg:
  - state enum rx_state_t {WAIT_SOF, IN_FRAME};
  - error bit index constants ERR_SOF_MISSING = 0, ERR_SOF_EARLY = 1, ERR_EOL_EARLY = 2, ERR_EOL_MISSING = 3.
- One sub-module, video_xy_counter: x/y counters with load, line-end and frame-end outputs, parameterized by DIM_W. The top level holds the FSM, tready register, accumulator and flags.

Test Plan:
- WIDTH = 4, HEIGHT = 2, eight beats with data 0..7, tuser on beat 0, tlast on beats 3 and 7 -> o_frame_done pulses once; o_frame_ok = 1; o_checksum = 28; o_frame_cnt = 1; o_err = 0.
- Same frame repeated three times, back to back -> o_frame_cnt = 3; checksum 28 each time. A 4th frame preceded by 2 beats without tuser -> o_err = 4'b0001; that frame still ok = 1, cnt = 4.
- WIDTH = 4, HEIGHT = 2, tlast on beat 2 (x = 2), then a 4-pixel line with tlast -> err[2] set; frame completes after 7 beats with o_frame_ok = 0; o_frame_cnt increments.
- WIDTH = 4, HEIGHT = 2, no tlast anywhere -> err[3] set; frame completes after 8 beats with ok = 0. Then pulse i_clr_err -> o_err = 0 next cycle.
- tuser re-asserted on beat 5 of a frame, followed by a full 8-beat frame -> err[1] set; exactly one o_frame_done; o_frame_cnt = 1; checksum counts only the restarted frame.
- i_stall high for 10 cycles mid-frame with tvalid held -> tready low from the 2nd cycle; no beats lost or duplicated; checksum = 28. Assert i_areset mid-frame -> all outputs 0 and tready 0.
